// File: rtl/instr_seq_pkg.sv
// Shared types and helpers for the instruction timing sequencer.
package instr_seq_pkg;

  localparam int unsigned MIN_STEPS = 4;
  localparam int unsigned MAX_STEPS = 64;

  typedef enum logic [0:0] {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_t;

  // OR of set-bit positions; exact for a one-hot or all-zero vector
  function automatic logic [31:0] onehot_to_idx(input logic [MAX_STEPS-1:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_STEPS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Decoder-side request/step bundle for instr_sequencer.
// Optional single-step signals under INSTR_SEQUENCER_SINGLE_STEP_EN.
interface instr_sequencer_if #(
  parameter int unsigned NUM_STEPS = 10,
  parameter int unsigned CNT_W     = 16
);
  localparam int unsigned IDX_W = $clog2(NUM_STEPS);

  logic                 run;
  logic                 halt_req;
  logic                 end_instr;
  logic                 skip_en;
  logic [IDX_W-1:0]     skip_to;
  logic                 wait_in;
  logic                 enter;
  logic [NUM_STEPS-1:0] t;
  logic [IDX_W-1:0]     step_idx;
  logic                 running;
  logic                 halted;
  logic                 read;
  logic                 instr_done;
  logic [CNT_W-1:0]     instr_count;

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  logic step_mode;
  logic step_go;
  logic step_hold;

  modport master (
    output run, halt_req, end_instr, skip_en, skip_to, wait_in, enter, step_mode, step_go,
    input  t, step_idx, running, halted, read, instr_done, instr_count, step_hold
  );
  modport slave (
    input  run, halt_req, end_instr, skip_en, skip_to, wait_in, enter, step_mode, step_go,
    output t, step_idx, running, halted, read, instr_done, instr_count, step_hold
  );
`else
  modport master (
    output run, halt_req, end_instr, skip_en, skip_to, wait_in, enter,
    input  t, step_idx, running, halted, read, instr_done, instr_count
  );
  modport slave (
    input  run, halt_req, end_instr, skip_en, skip_to, wait_in, enter,
    output t, step_idx, running, halted, read, instr_done, instr_count
  );
`endif

endinterface

// File: rtl/instr_sequencer_step_encoder.sv
// One-hot step vector to binary step index (all-zero input gives 0).
module step_encoder
  import instr_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 10
) (
  input  logic [NUM_STEPS-1:0]         onehot_i,
  output logic [$clog2(NUM_STEPS)-1:0] idx_o
);
  localparam int unsigned IDX_W = $clog2(NUM_STEPS);

  assign idx_o = IDX_W'(onehot_to_idx(MAX_STEPS'(onehot_i)));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction timing sequencer: one-hot step chain with end/skip/stall/halt and retire counter.
// Optional single-step hold at t0 under INSTR_SEQUENCER_SINGLE_STEP_EN.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.slave   bus
);
  localparam int unsigned    IDX_W   = $clog2(NUM_STEPS);
  localparam logic [IDX_W:0] STEPS_W = (IDX_W+1)'(NUM_STEPS);

  seq_state_t           state_q, state_d;
  logic [NUM_STEPS-1:0] t_q, t_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     step_idx;
  logic                 running;
  logic                 stall;
  logic                 skip_ok;
  logic                 hold;

  step_encoder #(.NUM_STEPS(NUM_STEPS)) u_step_encoder (
    .onehot_i (t_q),
    .idx_o    (step_idx)
  );

  assign running = (state_q == SEQ_RUN);
  assign stall   = running && bus.wait_in && !bus.enter;

  // Only strictly forward, in-range targets are honoured
  assign skip_ok = bus.skip_en && (bus.skip_to > step_idx) && ({1'b0, bus.skip_to} < STEPS_W);

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  assign hold          = bus.step_mode && t_q[0] && !bus.step_go;
  assign bus.step_hold = running && bus.step_mode && t_q[0];
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      SEQ_RUN: begin
        if (bus.halt_req) begin
          state_d = SEQ_HALT;
          t_d     = '0;
        end else if (!stall && !hold) begin
          if (bus.end_instr || t_q[NUM_STEPS-1]) begin
            t_d    = NUM_STEPS'(1);
            done_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end else if (skip_ok) begin
            t_d = NUM_STEPS'(1) << bus.skip_to;
          end else begin
            t_d = t_q << 1;
          end
        end
      end
      SEQ_HALT: begin
        if (bus.run) begin
          state_d = SEQ_RUN;
          t_d     = NUM_STEPS'(1);
        end
      end
      default: begin
        state_d = SEQ_RUN;
        t_d     = NUM_STEPS'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_RUN;
      t_q     <= NUM_STEPS'(1);
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.t           = t_q;
  assign bus.step_idx    = step_idx;
  assign bus.running     = running;
  assign bus.halted      = (state_q == SEQ_HALT);
  assign bus.read        = stall;
  assign bus.instr_done  = done_q;
  assign bus.instr_count = cnt_q;

endmodule
